game_countdown_timer: RTL
=========================

Name: game_countdown_timer

Overview:
- Round timer for the game. Consumes the 1-cycle `one_sec_tick` pulse from the seconds timebase and counts a round down from `START_SEC` to zero.
- Supports pause/resume and saturating bonus-time insertion.
- Outputs:
  - `time_left` in binary, plus BCD digits for the HUD score/time renderer.
  - a low-time warning level.
  - a single-cycle `time_up` pulse that the game FSM uses to end the round.

Parameters:
- START_SEC, 60, seconds loaded on start; legal range 1..MAX_SEC
- MAX_SEC, 999, saturation ceiling for time_left; must be ≤ 999
- BONUS_SEC, 5, seconds added per bonus pulse
- WARN_SEC, 10, warning asserted while 1 ≤ time_left ≤ WARN_SEC in RUNNING/PAUSED

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- one_sec_tick  in  1  1-cycle pulse once per second
- start  in  1  1-cycle pulse: (re)load START_SEC and run
- pause  in  1  1-cycle pulse: freeze countdown
- resume  in  1  1-cycle pulse: continue countdown
- bonus  in  1  1-cycle pulse: add BONUS_SEC
- time_left  out  10  seconds remaining, binary
- bcd_hun  out  4  hundreds digit of time_left
- bcd_ten  out  4  tens digit
- bcd_one  out  4  ones digit
- running  out  1  high in RUNNING
- paused  out  1  high in PAUSED
- expired  out  1  high in EXPIRED
- warning  out  1  low-time flag
- time_up  out  1  1-cycle pulse on reaching zero

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, time_left=START_SEC, BCD digits = decimal of START_SEC.
  - running=paused=expired=warning=time_up=0.
  - rst overrides every input in the same cycle, including mid-RUNNING.
- All outputs are registered. Each output reflects state/time_left after the edge that caused the change: one cycle latency from input pulse to output change.
- BCD digits are always consistent with time_left on the same cycle; they are computed from the next value and registered together with it.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- IDLE:
  - start -> RUNNING with time_left=START_SEC.
  - tick, pause, resume and bonus are ignored.
- RUNNING:
  - tick: time_left -= 1.
  - If time_left was 1 on a tick: next time_left=0, state=EXPIRED, time_up=1 for exactly that cycle.
  - pause -> PAUSED; a tick in the same cycle is dropped.
  - bonus: time_left = min(time_left+BONUS_SEC, MAX_SEC).
  - bonus+tick in the same cycle: time_left = min(time_left+BONUS_SEC, MAX_SEC) - 1; no expiry is possible in that case.
  - resume is ignored.
- PAUSED:
  - ticks are ignored; time_left is held.
  - bonus is applied with saturation.
  - resume -> RUNNING. A tick in the resume cycle is ignored; counting starts on the next tick.
  - pause is ignored.
- EXPIRED:
  - time_left=0, expired=1.
  - tick, pause, resume and bonus are ignored.
- start in any non-reset state:
  - Reloads START_SEC and enters RUNNING.
  - Highest priority: overrides pause, resume, bonus and tick in the same cycle.
- Same-cycle priority: rst > start > pause/resume > bonus > tick.
- Arithmetic: sum is computed in 11 bits before saturation; no wrap at 1023; time_left never goes below 0.
- warning = (state ∈ {RUNNING, PAUSED}) && time_left ≤ WARN_SEC && time_left ≠ 0. Registered alongside time_left. 0 in IDLE/EXPIRED.
- time_up never asserts on consecutive cycles. It asserts exactly once per expiry and never on reset or start.
- Exactly one of running/paused/expired is high, or none (IDLE).

Test Plan:
- Reset, start, 60 ticks spaced 40 cycles apart:
  - time_left steps 60→59→…→0.
  - BCD steps 0/6/0 → 0/5/9 … → 0/0/0.
  - warning rises on the edge where time_left becomes 10, falls with expiry.
  - time_up is high exactly one cycle, coincident with time_left=0; expired=1 thereafter.
  - Further ticks leave time_left=0.
- Start, 5 ticks (time_left=55), pause, 10 ticks, resume coincident with a tick, 1 more tick:
  - time_left=55 through the pause and the resume-cycle tick.
  - time_left=54 after the next tick; paused high only between pause and resume.
- Set time_left to 997 (MAX_SEC=999), bonus → 999. Bonus+tick same cycle at 999 → 998. Bonus+tick at 40 → 44.
- time_left=1 with bonus+tick same cycle → 5, no time_up. Separately, start+pause+tick same cycle while at 30 → time_left=60, running=1.
- rst asserted mid-RUNNING at time_left=23 with a tick that cycle → time_left=60, IDLE, all flags 0. Ticks afterwards are ignored until start.
- After expiry, bonus/resume/pause are ignored. start → time_left=60, running=1, expired=0, no time_up pulse.

Source files
------------

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: round countdown with pause/resume, saturating bonus and BCD readout
module game_countdown_timer #(
  parameter int START_SEC = 60,
  parameter int MAX_SEC   = 999,
  parameter int BONUS_SEC = 5,
  parameter int WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_sec_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       resume,
  input  logic       bonus,
  output logic [9:0] time_left,
  output logic [3:0] bcd_hun,
  output logic [3:0] bcd_ten,
  output logic [3:0] bcd_one,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       warning,
  output logic       time_up
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  localparam logic [9:0]  START_V = 10'(START_SEC);
  localparam logic [10:0] MAX_V   = 11'(MAX_SEC);
  localparam logic [10:0] BONUS_V = 11'(BONUS_SEC);
  localparam logic [9:0]  WARN_V  = 10'(WARN_SEC);
  localparam logic [3:0]  S_HUN   = 4'(START_SEC / 100);
  localparam logic [3:0]  S_TEN   = 4'((START_SEC / 10) % 10);
  localparam logic [3:0]  S_ONE   = 4'(START_SEC % 10);
  state_t     state, state_n;
  logic [9:0] time_n, sat, hun_w, ten_w, one_w;
  logic [10:0] sum;
  logic       warn_n, up_n;
  // State register; every output is registered together with the next state and time
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      time_left <= START_V;
      bcd_hun   <= S_HUN;
      bcd_ten   <= S_TEN;
      bcd_one   <= S_ONE;
      running   <= 1'b0;
      paused    <= 1'b0;
      expired   <= 1'b0;
      warning   <= 1'b0;
      time_up   <= 1'b0;
    end else begin
      state     <= state_n;
      time_left <= time_n;
      bcd_hun   <= hun_w[3:0];
      bcd_ten   <= ten_w[3:0];
      bcd_one   <= one_w[3:0];
      running   <= state_n == RUN;
      paused    <= state_n == HOLD;
      expired   <= state_n == DONE;
      warning   <= warn_n;
      time_up   <= up_n;
    end
  end
  // Next state and time: start > pause/resume > bonus > tick; the 11-bit sum keeps the carry past 1023
  always_comb begin
    sum     = {1'b0, time_left} + BONUS_V;
    sat     = sum > MAX_V ? MAX_V[9:0] : sum[9:0];
    state_n = state;
    time_n  = time_left;
    if (start) begin
      state_n = RUN;
      time_n  = START_V;
    end else if (state == RUN && pause) state_n = HOLD;
    else if (state == HOLD && resume) state_n = RUN;
    else if (state == HOLD) time_n = bonus ? sat : time_left;
    else if (state == RUN) begin
      time_n = bonus ? sat : time_left;
      time_n = (one_sec_tick && time_n != 10'd0) ? time_n - 10'd1 : time_n;
      state_n = time_n == 10'd0 ? DONE : RUN;
    end
  end
  // Outputs derived from the next state/time so they land on the same edge
  always_comb begin
    hun_w  = time_n / 10'd100;
    ten_w  = (time_n / 10'd10) % 10'd10;
    one_w  = time_n % 10'd10;
    warn_n = (state_n == RUN || state_n == HOLD) && time_n != 10'd0 && time_n <= WARN_V;
    up_n   = state == RUN && state_n == DONE;
  end
endmodule
